// File: rtl/sha_pkg.sv
// Shared types and helpers for the nonce hit filter: hash/nonce widths,
// compact-target field positions, target expansion and share-target easing.
package sha_pkg;

    localparam int HASH_W  = 256;
    localparam int NONCE_W = 32;
    localparam int LANE_W  = 64;
    localparam int LANES   = HASH_W / LANE_W;

    localparam int TB_EXP_MSB  = 31;
    localparam int TB_EXP_LSB  = 24;
    localparam int TB_SIGN     = 23;
    localparam int TB_MANT_MSB = 22;

    typedef logic [HASH_W-1:0] target_t;

    typedef struct packed {
        logic               share;
        logic [NONCE_W-1:0] nonce;
    } fifo_entry_t;

    function automatic target_t expand_target(input logic [31:0] bits);
        logic [7:0]  e;
        logic [22:0] m;
        logic [10:0] sh;
        target_t     full_m;
        target_t     t;
        e      = bits[TB_EXP_MSB:TB_EXP_LSB];
        m      = bits[TB_MANT_MSB:0];
        full_m = {{(HASH_W-23){1'b0}}, m};
        t      = '0;
        if (bits[TB_SIGN] || (m == '0)) begin
            t = '0;
        end else if (e <= 8'd3) begin
            sh = 11'd24 - {e, 3'b000};
            t  = full_m >> sh;
        end else if (e <= 8'd32) begin
            sh = {e, 3'b000} - 11'd24;
            t  = full_m << sh;
        end else begin
            t = '1;
        end
        return t;
    endfunction

    // Shift left and fill the vacated bits with ones; any bit shifted out saturates.
    function automatic target_t ease_target(input target_t t, input int unsigned shift);
        target_t ones;
        target_t r;
        ones = '1;
        if ((t >> (HASH_W - shift)) != '0) r = ones;
        else                                r = (t << shift) | ~(ones << shift);
        return r;
    endfunction

    // Lane 0 is least significant; the highest lane with a decision wins.
    function automatic logic lanes_le(input logic [LANES-1:0] lt, input logic [LANES-1:0] eq);
        logic le;
        le = 1'b1;
        for (int i = 0; i < LANES; i++) le = lt[i] | (eq[i] & le);
        return le;
    endfunction

endpackage

// File: rtl/nonce_hit_fifo.sv
// First-word-fall-through FIFO of {share, nonce} entries with a saturating
// drop counter for pushes that find the FIFO full.
module nonce_hit_fifo import sha_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_valid,
    input  logic               push_share,
    input  logic [NONCE_W-1:0] push_nonce,
    input  logic               pop,
    output logic               head_valid,
    output logic               head_share,
    output logic [NONCE_W-1:0] head_nonce,
    output logic [7:0]         drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]    drop_q, drop_d;
    fifo_entry_t   mem_q [DEPTH];
    fifo_entry_t   head_entry;
    logic          empty, full, do_push, do_pop;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves a latch.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop & ~empty;
        do_push  = push_valid & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        drop_d   = drop_q;
        if (push_valid && full && !do_pop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= '{share: push_share, nonce: push_nonce};
    end

    always_comb begin
        head_entry = mem_q[rd_ptr_q[AW-1:0]];
        head_valid = ~empty;
        head_share = empty ? 1'b0 : head_entry.share;
        head_nonce = empty ? '0   : head_entry.nonce;
        drop_count = drop_q;
    end

endmodule

// File: rtl/nonce_hit_filter.sv
// Checks each finished double-SHA hash against the compact target and buffers
// winning nonces. Optional share target enabled by macro SHARE_TARGET_EN.
module nonce_hit_filter import sha_pkg::*; #(
    parameter int FIFO_DEPTH = 4
`ifdef SHARE_TARGET_EN
    ,
    parameter int SHARE_SHIFT = 8
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hash_valid,
    input  logic [HASH_W-1:0]  hash_in,
    input  logic [NONCE_W-1:0] nonce_in,
    input  logic [31:0]        target_bits,
    output logic               found_valid,
    output logic [NONCE_W-1:0] found_nonce,
    output logic               found_share,
    input  logic               found_pop,
    output logic [7:0]         drop_count
);

    target_t            target_q, target_d;
    logic               s1_valid_q;
    target_t            s1_value_q, s1_value_d;
    logic [NONCE_W-1:0] s1_nonce_q;
    logic               s2_valid_q;
    logic [NONCE_W-1:0] s2_nonce_q;
    logic [LANES-1:0]   s2_blk_lt_q, s2_blk_lt_d, s2_blk_eq_q, s2_blk_eq_d;
    logic               blk_hit, shr_hit, push_valid, push_share;

    // Byte 0 of the hash is the least-significant byte of the compare value.
    always_comb begin
        target_d   = expand_target(target_bits);
        s1_value_d = '0;
        for (int i = 0; i < HASH_W / 8; i++) s1_value_d[8*i +: 8] = hash_in[HASH_W-8-8*i +: 8];
        s2_blk_lt_d = '0;
        s2_blk_eq_d = '0;
        for (int i = 0; i < LANES; i++) begin
            s2_blk_lt_d[i] = s1_value_q[LANE_W*i +: LANE_W] <  target_q[LANE_W*i +: LANE_W];
            s2_blk_eq_d[i] = s1_value_q[LANE_W*i +: LANE_W] == target_q[LANE_W*i +: LANE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_value_q  <= '0;
            s1_nonce_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_nonce_q  <= '0;
            s2_blk_lt_q <= '0;
            s2_blk_eq_q <= '0;
        end else begin
            target_q    <= target_d;
            s1_valid_q  <= hash_valid;
            s1_value_q  <= s1_value_d;
            s1_nonce_q  <= nonce_in;
            s2_valid_q  <= s1_valid_q;
            s2_nonce_q  <= s1_nonce_q;
            s2_blk_lt_q <= s2_blk_lt_d;
            s2_blk_eq_q <= s2_blk_eq_d;
        end
    end

`ifdef SHARE_TARGET_EN
    target_t          share_target_q, share_target_d;
    logic [LANES-1:0] s2_shr_lt_q, s2_shr_lt_d, s2_shr_eq_q, s2_shr_eq_d;

    always_comb begin
        share_target_d = ease_target(target_d, SHARE_SHIFT);
        s2_shr_lt_d    = '0;
        s2_shr_eq_d    = '0;
        for (int i = 0; i < LANES; i++) begin
            s2_shr_lt_d[i] = s1_value_q[LANE_W*i +: LANE_W] <  share_target_q[LANE_W*i +: LANE_W];
            s2_shr_eq_d[i] = s1_value_q[LANE_W*i +: LANE_W] == share_target_q[LANE_W*i +: LANE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            share_target_q <= '0;
            s2_shr_lt_q    <= '0;
            s2_shr_eq_q    <= '0;
        end else begin
            share_target_q <= share_target_d;
            s2_shr_lt_q    <= s2_shr_lt_d;
            s2_shr_eq_q    <= s2_shr_eq_d;
        end
    end
`endif

    // The share target is never below the block target, so a share-only hit is shr & ~blk.
    always_comb begin
        blk_hit = lanes_le(s2_blk_lt_q, s2_blk_eq_q);
`ifdef SHARE_TARGET_EN
        shr_hit = lanes_le(s2_shr_lt_q, s2_shr_eq_q);
`else
        shr_hit = 1'b0;
`endif
        push_valid = s2_valid_q & (blk_hit | shr_hit);
        push_share = shr_hit & ~blk_hit;
    end

    nonce_hit_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_share (push_share),
        .push_nonce (s2_nonce_q),
        .pop        (found_pop),
        .head_valid (found_valid),
        .head_share (found_share),
        .head_nonce (found_nonce),
        .drop_count (drop_count)
    );

endmodule

// File: tb/tb_nonce_hit_filter.sv
// Randomized self-checking bench for nonce_hit_filter against a transaction-level
// model (arithmetic target expansion, queue-based FIFO, two-cycle delay line).
module tb_nonce_hit_filter;

    localparam int DEPTH = 4;
    localparam int SHIFT = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         hash_valid;
    logic [255:0] hash_in;
    logic [31:0]  nonce_in;
    logic [31:0]  target_bits;
    logic         found_valid;
    logic [31:0]  found_nonce;
    logic         found_share;
    logic         found_pop;
    logic [7:0]   drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: queue of {share, nonce}, saturating drop count, two-stage delay line.
    logic [32:0] mq[$];
    int          m_drop;
    logic        s1_push, s2_push;
    logic [32:0] s1_ent, s2_ent;

    nonce_hit_filter #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hash_valid  (hash_valid),
        .hash_in     (hash_in),
        .nonce_in    (nonce_in),
        .target_bits (target_bits),
        .found_valid (found_valid),
        .found_nonce (found_nonce),
        .found_share (found_share),
        .found_pop   (found_pop),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] ref_target(input logic [31:0] tb);
        int unsigned e;
        int unsigned m;
        logic [255:0] t;
        e = int'(tb[31:24]);
        m = int'(tb[22:0]);
        if (tb[23] || m == 0) return '0;
        if (e <= 3) return 256'(m / (32'd1 << (8 * (3 - e))));
        if (e > 32) return '1;
        t = 256'(m);
        for (int k = 0; k < int'(e) - 3; k++) t = t * 256;
        return t;
    endfunction

    function automatic logic [255:0] ref_share(input logic [255:0] t);
        logic [255:0] lim;
        lim = 256'd1 << (256 - SHIFT);
        if (t >= lim) return '1;
        return t * (256'd1 << SHIFT) + ((256'd1 << SHIFT) - 1);
    endfunction

    // Hash byte k (counting from the top) carries weight 256^k; the mapping is its own inverse.
    function automatic logic [255:0] rev_bytes(input logic [255:0] h);
        logic [255:0] v;
        v = '0;
        for (int k = 31; k >= 0; k--) v = v * 256 + ((h >> (8 * (31 - k))) & 256'hff);
        return v;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r = (r << 32) | 256'($urandom);
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_drop  = 0;
        s1_push = 1'b0;
        s2_push = 1'b0;
        s1_ent  = '0;
        s2_ent  = '0;
    endtask

    // Applies one clock edge to the model using the inputs held across that edge.
    task automatic model_edge();
        logic [255:0] v, t;
        logic blk, shr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (found_pop && mq.size() > 0) void'(mq.pop_front());
        if (s2_push) begin
            if (mq.size() < DEPTH) mq.push_back(s2_ent);
            else if (m_drop < 255) m_drop++;
        end
        s2_push = s1_push;
        s2_ent  = s1_ent;
        v   = rev_bytes(hash_in);
        t   = ref_target(target_bits);
        blk = (v <= t);
`ifdef SHARE_TARGET_EN
        shr = (v <= ref_share(t));
`else
        shr = 1'b0;
`endif
        s1_push = hash_valid && (blk || shr);
        s1_ent  = {shr && !blk, nonce_in};
    endtask

    task automatic check_outputs();
        check("valid", 64'(found_valid), 64'(mq.size() > 0));
        check("nonce", 64'(found_nonce), (mq.size() > 0) ? 64'(mq[0][31:0]) : 64'd0);
        check("share", 64'(found_share), (mq.size() > 0) ? 64'(mq[0][32]) : 64'd0);
        check("drops", 64'(drop_count), 64'(m_drop));
    endtask

    task automatic cycle(input logic v, input logic [255:0] h, input logic [31:0] n, input logic pop);
        hash_valid = v;
        hash_in    = h;
        nonce_in   = n;
        found_pop  = pop;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0);
    endtask

    task automatic set_target(input logic [31:0] tb);
        target_bits = tb;
        idle(2);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && found_valid; i++) cycle(1'b0, '0, '0, 1'b1);
        check("drain_empty", 64'(found_valid), 64'd0);
    endtask

    logic [255:0] h;
    logic [255:0] tgt;
    logic [31:0]  tlist [10];

    initial begin
        tlist = '{32'h1d00ffff, 32'h1f00ffff, 32'h2100ffff, 32'h1d80ffff, 32'h03123456,
                  32'h01003456, 32'h207fffff, 32'h04000000, 32'h02008000, 32'h2000ffff};
        model_reset();
        rst_n       = 1'b0;
        hash_valid  = 1'b0;
        hash_in     = '0;
        nonce_in    = '0;
        found_pop   = 1'b0;
        target_bits = 32'h1d00ffff;
        idle(2);
        check("rst_valid", 64'(found_valid), 64'd0);
        check("rst_nonce", 64'(found_nonce), 64'd0);
        check("rst_drop",  64'(drop_count),  64'd0);
        rst_n = 1'b1;
        idle(2);

        // Zero hash hits the difficulty-1 target two edges after sampling.
        cycle(1'b1, '0, 32'h12345678, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        check("t1_early", 64'(found_valid), 64'd0);
        cycle(1'b0, '0, '0, 1'b0);
        check("t1_valid", 64'(found_valid), 64'd1);
        check("t1_nonce", 64'(found_nonce), 64'h12345678);
        check("t1_share", 64'(found_share), 64'd0);
        drain();

        // First hash byte is the LSB of the value; last hash byte is the MSB.
        h = '0; h[255:248] = 8'h01;
        cycle(1'b1, h, 32'hA1, 1'b0);
        idle(2);
        check("t2_lsb_hit", 64'(found_nonce), 64'hA1);
        drain();
        h = '0; h[7:0] = 8'h01;
        cycle(1'b1, h, 32'hA2, 1'b0);
        idle(2);
        check("t2_msb_miss", 64'(found_valid), 64'd0);

        // Exponent above 32: everything hits; overflow the FIFO by three.
        set_target(32'h2100ffff);
        for (int i = 0; i < DEPTH + 3; i++) cycle(1'b1, rand256(), 32'h100 + 32'(i), 1'b0);
        idle(2);
        check("t3_drop", 64'(drop_count), 64'd3);
        check("t3_head", 64'(found_nonce), 64'h100);

        // Push and pop on the same edge while full.
        cycle(1'b1, rand256(), 32'h200, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1);
        check("t4_drop", 64'(drop_count), 64'd3);
        check("t4_head", 64'(found_nonce), 64'h101);
        drain();

        // Sign bit set: only an all-zero value qualifies.
        set_target(32'h1d80ffff);
        cycle(1'b1, '1, 32'hB1, 1'b0);
        cycle(1'b1, '0, 32'hB2, 1'b0);
        idle(2);
        check("t5_head", 64'(found_nonce), 64'hB2);
        drain();

        // One above the block target: a share-only hit when the share target is built in.
        set_target(32'h1d00ffff);
        tgt = ref_target(32'h1d00ffff) + 1;
        cycle(1'b1, rev_bytes(tgt), 32'hC1, 1'b0);
        idle(2);
`ifdef SHARE_TARGET_EN
        check("t6_share_valid", 64'(found_valid), 64'd1);
        check("t6_share_flag",  64'(found_share), 64'd1);
`else
        check("t6_no_share", 64'(found_valid), 64'd0);
`endif
        drain();

        // Asynchronous reset in the middle of a stream with entries and drops present.
        set_target(32'h2100ffff);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b1, rand256(), 32'h300 + 32'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(found_valid), 64'd0);
        check("t6_rst_drop",  64'(drop_count),  64'd0);
        check("t6_rst_nonce", 64'(found_nonce), 64'd0);
        model_reset();
        idle(1);
        rst_n = 1'b1;
        idle(2);

        // Random traffic across a set of targets, including values on the target boundary.
        for (int blk = 0; blk < 30; blk++) begin
            set_target(tlist[$urandom_range(0, 9)]);
            tgt = ref_target(target_bits);
            for (int i = 0; i < 40; i++) begin
                case ($urandom_range(0, 5))
                    0: h = rand256();
                    1: h = rev_bytes(tgt);
                    2: h = rev_bytes(tgt + 1);
                    3: h = rev_bytes(tgt - 1);
                    4: h = '0;
                    default: h = rev_bytes(rand256() >> (8 * $urandom_range(0, 31)));
                endcase
                cycle($urandom_range(0, 3) != 0, h, $urandom, $urandom_range(0, 2) == 0);
            end
        end
        idle(2);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
